// File: rtl/spi_pkg.sv
// spi_pkg: shared constants and the frame FSM state type for the SPI register bank.
// Frame layout (MSB first): [15] R/W (1 = write), [14:12] reserved, [11:8] address, [7:0] data.
package spi_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned ADDR_MSB   = 11;
  localparam int unsigned ADDR_LSB   = 8;
  localparam int unsigned RW_BIT     = 15;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    DONE
  } spi_state_t;

endpackage

// File: rtl/synchronizer.sv
// synchronizer: multi-flop synchroniser for one asynchronous input bit.
// Ports:
//   clk_i - destination clock
//   rst_i - synchronous active-high reset, loads RESET_VAL into every stage
//   d_i   - asynchronous input
//   q_o   - synchronised output (STAGES clk edges of latency)
// STAGES must be at least 2.
module synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_bank.sv
// spi_reg_bank: SPI mode-0 peripheral (oversampled in the clk domain) fronting a small
// register file. One 16-bit frame writes or reads one register.
// Ports:
//   clk, rst              - system clock, synchronous active-high reset
//   spi_sclk/cs_n/mosi    - asynchronous SPI pins
//   spi_miso, spi_miso_oe - serial read data and its output enable
//   regs                  - flattened registers, register i at [i*REG_W +: REG_W]
//   wr_strobe, wr_addr    - one-cycle write-commit pulse and last committed address
module spi_reg_bank
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS = 4,
  parameter int unsigned REG_W    = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      spi_sclk,
  input  logic                      spi_cs_n,
  input  logic                      spi_mosi,
  output logic                      spi_miso,
  output logic                      spi_miso_oe,
  output logic [NUM_REGS*REG_W-1:0] regs,
  output logic                      wr_strobe,
  output logic [3:0]                wr_addr
);

  localparam int unsigned DATA_BITS = FRAME_BITS / 2;

  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise, sclk_fall, cs_fall;

  synchronizer #(.STAGES(2), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk_i(clk), .rst_i(rst), .d_i(spi_sclk), .q_o(sclk_s)
  );
  synchronizer #(.STAGES(2), .RESET_VAL(1'b1)) u_sync_cs (
    .clk_i(clk), .rst_i(rst), .d_i(spi_cs_n), .q_o(cs_s)
  );
  synchronizer #(.STAGES(2), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk_i(clk), .rst_i(rst), .d_i(spi_mosi), .q_o(mosi_s)
  );

  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;

  spi_state_t             state_q, state_d;
  logic [3:0]             cnt_q, cnt_d;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [7:0]             miso_sr_q, miso_sr_d;
  logic                   miso_q, miso_d;
  logic                   strobe_q, strobe_d;
  logic [3:0]             wr_addr_q, wr_addr_d;
  logic [REG_W-1:0]       regs_q [NUM_REGS];
  logic [REG_W-1:0]       regs_d [NUM_REGS];
  // Synchroniser outputs carry reset values, not pin levels, for the first cycles after
  // reset. A frame is only accepted once CS_N has been genuinely observed high.
  logic [1:0]             warm_q, warm_d;
  logic                   armed_q, armed_d;

  logic [FRAME_BITS-1:0]  frame_next;
  logic [3:0]             cmd_addr, frm_addr;
  logic [7:0]             rd_val;
  logic                   wr_hit;

  always_comb begin
    // Frame as it stands including the bit sampled on this edge.
    frame_next = {shift_q[FRAME_BITS-2:0], mosi_s};
    // After 8 bits the address sits in the low nibble of the shift register.
    cmd_addr   = frame_next[ADDR_MSB-DATA_BITS:ADDR_LSB-DATA_BITS];
    frm_addr   = frame_next[ADDR_MSB:ADDR_LSB];

    rd_val = '0;
    wr_hit = 1'b0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (cmd_addr == 4'(i)) rd_val[REG_W-1:0] = regs_q[i];
      if (frm_addr == 4'(i)) wr_hit = 1'b1;
    end

    state_d   = state_q;
    cnt_d     = cnt_q;
    shift_d   = shift_q;
    miso_sr_d = miso_sr_q;
    miso_d    = miso_q;
    strobe_d  = 1'b0;
    wr_addr_d = wr_addr_q;
    regs_d    = regs_q;
    warm_d    = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
    armed_d   = armed_q | ((warm_q == 2'd3) & cs_s);

    unique case (state_q)
      IDLE: begin
        if (cs_fall && armed_q) begin
          state_d = CMD;
          cnt_d   = '0;
          shift_d = '0;
        end
      end
      CMD: begin
        if (sclk_rise) begin
          shift_d = frame_next;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd7) begin
            state_d   = DATA;
            miso_sr_d = rd_val;
          end
        end
      end
      DATA: begin
        if (sclk_rise) begin
          shift_d = frame_next;
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q == 4'd15) begin
            state_d = DONE;
            miso_d  = 1'b0;
            if (frame_next[RW_BIT] && wr_hit) begin
              for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (frm_addr == 4'(i)) regs_d[i] = frame_next[REG_W-1:0];
              end
              strobe_d  = 1'b1;
              wr_addr_d = frm_addr;
            end
          end
        end else if (sclk_fall) begin
          // Present on the falling edge so the host samples on the next rise.
          miso_d    = miso_sr_q[7];
          miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end
      end
      DONE: ;
      default: state_d = IDLE;
    endcase

    // Deselect wins after any commit on the same cycle.
    if (cs_s) begin
      state_d = IDLE;
      miso_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      miso_sr_q   <= '0;
      miso_q      <= 1'b0;
      strobe_q    <= 1'b0;
      wr_addr_q   <= '0;
      regs_q      <= '{default: '0};
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      warm_q      <= '0;
      armed_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      miso_sr_q   <= miso_sr_d;
      miso_q      <= miso_d;
      strobe_q    <= strobe_d;
      wr_addr_q   <= wr_addr_d;
      regs_q      <= regs_d;
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      warm_q      <= warm_d;
      armed_q     <= armed_d;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*REG_W +: REG_W] = regs_q[g];
  end

  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_s;
  assign wr_strobe   = strobe_q;
  assign wr_addr     = wr_addr_q;

endmodule
